// File: rtl/div32_seq_pkg.sv
// Shared constants, state encoding and sign helpers for the sequential MIPS divider.
package div32_seq_pkg;

    localparam int DIV_STEPS = 32;
    localparam int DIV_CNT_W = 5;
    localparam logic [31:0] DIV_DZ_Q = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } div_state_e;

    function automatic logic [31:0] div_mag(input logic [31:0] value, input logic as_signed);
        return (as_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

    function automatic logic [31:0] div_apply_sign(input logic [31:0] mag, input logic neg);
        return neg ? (~mag + 32'd1) : mag;
    endfunction

endpackage

// File: rtl/div32_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract the divisor.
module div32_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic             qbit
);

    logic [WIDTH:0] rem33;
    logic [WIDTH:0] trial;

    // A clear borrow bit means the shifted remainder covered the divisor.
    always_comb begin
        rem33   = {rem_in, dvd_bit};
        trial   = rem33 - {1'b0, dvs};
        qbit    = ~trial[WIDTH];
        rem_out = qbit ? trial[WIDTH-1:0] : rem33[WIDTH-1:0];
    end

endmodule

// File: rtl/div32_seq.sv
// Multicycle 32-bit restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// abortable by cancel, results held in q/r/dz until the next completion.
module div32_seq
    import div32_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    div_state_e           state;
    div_state_e           next_state;
    logic [DIV_CNT_W-1:0] count;
    logic [WIDTH-1:0]     dvd;
    logic [WIDTH-1:0]     dvs;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     step_rem;
    logic                 step_qbit;
    logic                 sign_q;
    logic                 sign_r;
    logic                 dz_pend;
    logic                 accept;
    logic                 finish;

    div32_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .dvd_bit (dvd[WIDTH-1]),
        .dvs     (dvs),
        .rem_out (step_rem),
        .qbit    (step_qbit)
    );

    assign busy = (state == ST_RUN);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Cancel outranks both a new request and the final step.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !cancel) begin
                    next_state = ST_RUN;
                    accept     = 1'b1;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    next_state = ST_IDLE;
                end else if (count == DIV_CNT_W'(DIV_STEPS - 1)) begin
                    next_state = ST_IDLE;
                    finish     = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // The dividend register doubles as the quotient shift register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
            count   <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dz_pend <= 1'b0;
        end else if (accept) begin
            dvd     <= div_mag(a, is_signed);
            dvs     <= div_mag(b, is_signed);
            rem     <= '0;
            count   <= '0;
            sign_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r  <= is_signed & a[WIDTH-1];
            dz_pend <= (b == '0);
        end else if (cancel) begin
            count <= '0;
        end else if (state == ST_RUN) begin
            rem   <= step_rem;
            dvd   <= {dvd[WIDTH-2:0], step_qbit};
            count <= count + DIV_CNT_W'(1);
        end
    end

    // With b==0 every trial succeeds, so the remainder path rebuilds the raw dividend.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ready <= 1'b0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
        end else begin
            ready <= finish;
            if (finish) begin
                q  <= dz_pend ? DIV_DZ_Q : div_apply_sign({dvd[WIDTH-2:0], step_qbit}, sign_q);
                r  <= div_apply_sign(step_rem, sign_r);
                dz <= dz_pend;
            end
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: expected results queued at each accepted start,
// compared against q/r/dz and latency whenever ready pulses.
module tb_div32_seq;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          start_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        ready;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          assert_count = 0;
    int          fail_count = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;
    logic        last_dz = 1'b0;

    div32_seq dut (
        .clk       (clk),
        .clrn      (clrn),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .cancel    (cancel),
        .busy      (busy),
        .ready     (ready),
        .q         (q),
        .r         (r),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a_v, input logic [31:0] b_v, input logic sgn);
        exp_t e;
        int   sa;
        int   sbv;
        e.start_cyc = 0;
        e.dz        = 1'b0;
        if (b_v == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a_v;
            e.dz = 1'b1;
        end else if (sgn && a_v == 32'h8000_0000 && b_v == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else if (sgn) begin
            sa  = a_v;
            sbv = b_v;
            e.q = 32'(sa / sbv);
            e.r = 32'(sa % sbv);
        end else begin
            e.q = a_v / b_v;
            e.r = a_v % b_v;
        end
        return e;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_ready", 32'(ready), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("q", q, e.q);
                checkOutput("r", r, e.r);
                checkOutput("dz", 32'(dz), 32'(e.dz));
                checkOutput("latency", 32'(cyc - e.start_cyc), 32'd32);
                checkOutput("busy_at_ready", 32'(busy), 32'd0);
                last_q  = e.q;
                last_r  = e.r;
                last_dz = e.dz;
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a_v, input logic [31:0] b_v, input logic sgn);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        if (busy) checkOutput("idle_wait", 32'(busy), 32'd0);
        a         = a_v;
        b         = b_v;
        is_signed = sgn;
        start     = 1'b1;
        e = model(a_v, b_v, sgn);
        @(posedge clk);
        #1;
        start       = 1'b0;
        a           = $urandom;
        b           = $urandom;
        is_signed   = 1'($urandom_range(0, 1));
        e.start_cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic cancelAt(input int n);
        repeat (n) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        checkOutput("cancel_busy", 32'(busy), 32'd0);
        checkOutput("cancel_hold_q", q, last_q);
        checkOutput("cancel_hold_r", r, last_r);
        checkOutput("cancel_hold_dz", 32'(dz), 32'(last_dz));
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int          busy_cycles;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_q", q, 32'd0);
        checkOutput("rst_r", r, 32'd0);
        checkOutput("rst_dz", 32'(dz), 32'd0);
        clrn = 1'b1;

        // DIVU 100/7 with busy-length check and a start poked mid-run.
        applyStimulus(32'd100, 32'd7, 1'b0);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 5) begin
                start     = 1'b1;
                a         = 32'd9;
                b         = 32'd3;
                is_signed = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cycles++;
            if (ready) break;
        end
        start = 1'b0;
        checkOutput("busy_cycles", 32'(busy_cycles), 32'd32);
        waitDrain();

        // Signed cases, divide by zero, signed overflow.
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1);
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1);
        applyStimulus(32'd5, 32'd0, 1'b0);
        applyStimulus(32'hFFFF_FFFB, 32'd0, 1'b1);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(32'h8000_0000, 32'd3, 1'b1);
        waitDrain();

        // Back-to-back: second start lands on the first idle cycle.
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0);
        applyStimulus(32'd1000, 32'd10, 1'b0);
        waitDrain();

        // Cancel mid-run, then cancel coinciding with an idle start.
        applyStimulus(32'd12345, 32'd67, 1'b0);
        waitDrain();
        applyStimulus(32'd999999, 32'd3, 1'b1);
        cancelAt(10);
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        checkOutput("cancel_start_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        applyStimulus(32'd77, 32'd5, 1'b0);
        cancelAt(32);
        repeat (5) @(negedge clk);

        // Asynchronous reset between edges mid-run.
        applyStimulus(32'd50000, 32'd13, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        clrn = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_ready", 32'(ready), 32'd0);
        checkOutput("arst_q", q, 32'd0);
        checkOutput("arst_r", r, 32'd0);
        checkOutput("arst_dz", 32'(dz), 32'd0);
        exp_q.delete();
        last_q  = '0;
        last_r  = '0;
        last_dz = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        applyStimulus(32'd81, 32'd9, 1'b0);
        waitDrain();

        // Random operations with occasional zero divisors and cancels.
        for (int i = 0; i < 600; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 99) < 5) rb = 32'd0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
            else rb = $urandom;
            if ($urandom_range(0, 15) == 0) rb = 32'hFFFF_FFFF;
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) cancelAt($urandom_range(1, 32));
        end
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
